// File: rtl/network_vc_link_arbiter_if.sv
// rtl/network_vc_link_arbiter_if.sv - VC-side and link-side signal bundle for the VC link arbiter
interface network_vc_link_arbiter_if #(
    parameter int NetworkFlitWidth               = 64,
    parameter int NetworkFlitTypeWidth           = 2,
    parameter int NetworkBroadcastWidth          = 1,
    parameter int NetworkNumberOfVirtualChannels = 4,
    parameter int NetworkVirtualChannelIdWidth   = 2
);
    localparam int SliceWidth       = NetworkFlitWidth + NetworkFlitTypeWidth + NetworkBroadcastWidth;
    localparam int NetworkDataWidth = SliceWidth + NetworkVirtualChannelIdWidth;

    logic [NetworkNumberOfVirtualChannels-1:0]            vc_valid_i;
    logic [NetworkNumberOfVirtualChannels*SliceWidth-1:0] vc_data_i;
    logic [NetworkNumberOfVirtualChannels-1:0]            vc_ready_o;
    logic [NetworkNumberOfVirtualChannels-1:0]            network_go_i;
    logic                                                 network_valid_o;
    logic [NetworkDataWidth-1:0]                          network_data_o;
    logic                                                 protocol_error_o;
    logic [NetworkVirtualChannelIdWidth-1:0]              error_vc_o;
    logic [31:0]                                          flit_count_o;

    modport master (
        output vc_valid_i, vc_data_i, network_go_i,
        input  vc_ready_o, network_valid_o, network_data_o,
        input  protocol_error_o, error_vc_o, flit_count_o
    );

    modport slave (
        input  vc_valid_i, vc_data_i, network_go_i,
        output vc_ready_o, network_valid_o, network_data_o,
        output protocol_error_o, error_vc_o, flit_count_o
    );
endinterface

// File: rtl/network_vc_link_arbiter.sv
// rtl/network_vc_link_arbiter.sv - round-robin VC scheduler onto one registered inter-tile link
// Optional wormhole packet lock: NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
module network_vc_link_arbiter #(
    parameter int NetworkFlitWidth               = 64,
    parameter int NetworkFlitTypeWidth           = 2,
    parameter int NetworkBroadcastWidth          = 1,
    parameter int NetworkNumberOfVirtualChannels = 4,
    parameter int NetworkVirtualChannelIdWidth   = 2
) (
    input  logic                      clk_network_i,
    input  logic                      rst_network_i,
    network_vc_link_arbiter_if.slave  bus
);
    localparam int FW    = NetworkFlitWidth;
    localparam int TW    = NetworkFlitTypeWidth;
    localparam int NVC   = NetworkNumberOfVirtualChannels;
    localparam int VCIDW = NetworkVirtualChannelIdWidth;
    localparam int SW    = NetworkFlitWidth + NetworkFlitTypeWidth + NetworkBroadcastWidth;
    localparam int DW    = SW + VCIDW;

    localparam logic [TW-1:0] FT_HEADER = TW'(0);
    localparam logic [TW-1:0] FT_BODY   = TW'(1);
    localparam logic [TW-1:0] FT_TAIL   = TW'(2);

    logic [VCIDW-1:0] ptr_q, ptr_d;
    logic [NVC-1:0]   open_q, open_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             perr_q, perr_d;
    logic [VCIDW-1:0] err_vc_q, err_vc_d;
    logic [31:0]      cnt_q, cnt_d;

    logic [NVC-1:0]   elig;
    logic [NVC-1:0]   grant;
    logic             gnt_any;
    logic [VCIDW-1:0] gnt_id;
    logic [VCIDW-1:0] idx;
    logic [SW-1:0]    gnt_slice;
    logic [TW-1:0]    gnt_type;
    logic             viol;

`ifdef NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
    logic             lock_active_q, lock_active_d;
    logic [VCIDW-1:0] lock_vc_q, lock_vc_d;
`endif

    always_comb begin
        elig = bus.vc_valid_i & bus.network_go_i;
`ifdef NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
        // A locked link only serves the VC that owns the open packet.
        if (lock_active_q) begin
            elig = elig & ({{(NVC-1){1'b0}}, 1'b1} << lock_vc_q);
        end
`endif
    end

    // Search ascends from the pointer and wraps; first eligible VC wins.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = 0; i < NVC; i++) begin
            idx = VCIDW'((int'(ptr_q) + i) % NVC);
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (rst_network_i) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            grant[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        open_d      = open_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        perr_d      = perr_q;
        err_vc_d    = err_vc_q;
        cnt_d       = cnt_q;
        viol        = 1'b0;
        gnt_slice   = bus.vc_data_i[int'(gnt_id)*SW +: SW];
        gnt_type    = gnt_slice[FW +: TW];
`ifdef NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
        lock_active_d = lock_active_q;
        lock_vc_d     = lock_vc_q;
`endif
        if (gnt_any) begin
            out_valid_d = 1'b1;
            out_data_d  = {gnt_id, gnt_slice};
            cnt_d       = cnt_q + 32'd1;
            ptr_d       = (int'(gnt_id) == NVC - 1) ? '0 : gnt_id + VCIDW'(1);
            // Violating flits are still forwarded; only the flag records them.
            case (gnt_type)
                FT_HEADER: begin
                    viol           = open_q[gnt_id];
                    open_d[gnt_id] = 1'b1;
                end
                FT_BODY: begin
                    viol = !open_q[gnt_id];
                end
                FT_TAIL: begin
                    viol           = !open_q[gnt_id];
                    open_d[gnt_id] = 1'b0;
                end
                default: begin
                    viol = open_q[gnt_id];
                end
            endcase
            if (viol && !perr_q) begin
                perr_d   = 1'b1;
                err_vc_d = gnt_id;
            end
`ifdef NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
            if (gnt_type == FT_HEADER) begin
                lock_active_d = 1'b1;
                lock_vc_d     = gnt_id;
            end else if (gnt_type == FT_TAIL && lock_active_q && gnt_id == lock_vc_q) begin
                lock_active_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk_network_i) begin
        if (rst_network_i) begin
            ptr_q       <= '0;
            open_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            perr_q      <= 1'b0;
            err_vc_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            open_q      <= open_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            perr_q      <= perr_d;
            err_vc_q    <= err_vc_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef NETWORK_VC_LINK_ARBITER_PKTLOCK_EN
    always_ff @(posedge clk_network_i) begin
        if (rst_network_i) begin
            lock_active_q <= 1'b0;
            lock_vc_q     <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_vc_q     <= lock_vc_d;
        end
    end
`endif

    assign bus.vc_ready_o       = grant;
    assign bus.network_valid_o  = out_valid_q;
    assign bus.network_data_o   = out_data_q;
    assign bus.protocol_error_o = perr_q;
    assign bus.error_vc_o       = err_vc_q;
    assign bus.flit_count_o     = cnt_q;
endmodule
